// File: rtl/alu_issue_unit.sv
// Encodes symbolic ALU requests into MIPS instruction words, holds them on the ALU
// for EXEC_CYCLES cycles, then returns the sampled result/flags over a response handshake.
module alu_issue_unit #(
   parameter int EXEC_CYCLES = 1,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [4:0]       req_op,
   input  logic             req_rs_sel,
   input  logic             req_rt_sel,
   input  logic [15:0]      req_imm,
   input  logic [31:0]      req_a,
   input  logic [31:0]      req_b,
   output logic [31:0]      alu_instruction,
   output logic [31:0]      alu_regA,
   output logic [31:0]      alu_regB,
   input  logic [31:0]      alu_result,
   input  logic [2:0]       alu_flags,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_result,
   output logic [2:0]       rsp_flags,
   output logic             rsp_err,
   output logic [31:0]      rsp_instr,
   output logic [CNT_W-1:0] op_count
);

   localparam logic [31:0] NOP = 32'h0000_0021;

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t      state, state_nxt;
   logic [3:0]  cnt;
   logic [31:0] lat_word, lat_a, lat_b;
   logic [31:0] enc_word;
   logic [5:0]  funct, opcode;
   logic [4:0]  rs, rt;
   logic        is_r, legal;
   logic        accept, sample;

   always_comb begin
      rs     = {4'b0, req_rs_sel};
      rt     = {4'b0, req_rt_sel};
      funct  = 6'h00;
      opcode = 6'h00;
      is_r   = 1'b0;
      legal  = 1'b1;
      case (req_op)
         5'd0:  begin is_r = 1'b1; funct = 6'h20; end
         5'd1:  opcode = 6'h08;
         5'd2:  begin is_r = 1'b1; funct = 6'h21; end
         5'd3:  opcode = 6'h09;
         5'd4:  begin is_r = 1'b1; funct = 6'h22; end
         5'd5:  begin is_r = 1'b1; funct = 6'h23; end
         5'd6:  begin is_r = 1'b1; funct = 6'h24; end
         5'd7:  opcode = 6'h0C;
         5'd8:  begin is_r = 1'b1; funct = 6'h27; end
         5'd9:  begin is_r = 1'b1; funct = 6'h25; end
         5'd10: opcode = 6'h0D;
         5'd11: begin is_r = 1'b1; funct = 6'h26; end
         5'd12: opcode = 6'h0E;
         5'd13: opcode = 6'h04;
         5'd14: opcode = 6'h05;
         5'd15: begin is_r = 1'b1; funct = 6'h2A; end
         5'd16: opcode = 6'h0A;
         5'd17: opcode = 6'h0B;
         5'd18: begin is_r = 1'b1; funct = 6'h2B; end
         5'd19: opcode = 6'h23;
         5'd20: opcode = 6'h2B;
         default: legal = 1'b0;
      endcase
      enc_word = is_r ? {6'b0, rs, rt, 10'b0, funct} : {opcode, rs, rt, req_imm};
   end

   // Only EXEC exposes the latched word; everywhere else the ALU sees the NOP.
   always_comb begin
      state_nxt       = state;
      req_ready       = 1'b0;
      rsp_valid       = 1'b0;
      alu_instruction = NOP;
      accept          = 1'b0;
      sample          = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               accept    = 1'b1;
               state_nxt = legal ? EXEC : RESP;
            end
         end
         EXEC: begin
            alu_instruction = lat_word;
            if (cnt == 4'd0) begin
               sample    = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign alu_regA = lat_a;
   assign alu_regB = lat_b;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt        <= 4'd0;
         lat_word   <= NOP;
         lat_a      <= 32'h0;
         lat_b      <= 32'h0;
         rsp_result <= 32'h0;
         rsp_flags  <= 3'b0;
         rsp_err    <= 1'b0;
         rsp_instr  <= 32'h0;
         op_count   <= '0;
      end else begin
         if (accept) begin
            lat_word <= enc_word;
            lat_a    <= req_a;
            lat_b    <= req_b;
            cnt      <= 4'(EXEC_CYCLES - 1);
            if (!legal) begin
               rsp_err    <= 1'b1;
               rsp_result <= 32'h0;
               rsp_flags  <= 3'b0;
               rsp_instr  <= 32'h0;
            end
         end
         if (state == EXEC && !sample) cnt <= cnt - 4'd1;
         if (sample) begin
            rsp_result <= alu_result;
            rsp_flags  <= alu_flags;
            rsp_instr  <= lat_word;
            rsp_err    <= 1'b0;
         end
         if (state == RESP && rsp_ready && !rsp_err)
            op_count <= op_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Scoreboard bench for alu_issue_unit: directed requests against a small behavioural ALU stub.
module tb_alu_issue_unit;

   localparam int EXC = 3;
   localparam int CW  = 3;
   localparam logic [31:0] NOP = 32'h0000_0021;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_valid, req_ready, req_rs_sel, req_rt_sel;
   logic [4:0]    req_op;
   logic [15:0]   req_imm;
   logic [31:0]   req_a, req_b;
   logic [31:0]   alu_instruction, alu_regA, alu_regB, alu_result;
   logic [2:0]    alu_flags;
   logic          rsp_valid, rsp_ready, rsp_err;
   logic [31:0]   rsp_result, rsp_instr;
   logic [2:0]    rsp_flags;
   logic [CW-1:0] op_count;

   always #5 clk = ~clk;

   alu_issue_unit #(.EXEC_CYCLES(EXC), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_rs_sel(req_rs_sel), .req_rt_sel(req_rt_sel), .req_imm(req_imm),
      .req_a(req_a), .req_b(req_b),
      .alu_instruction(alu_instruction), .alu_regA(alu_regA), .alu_regB(alu_regB),
      .alu_result(alu_result), .alu_flags(alu_flags),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_flags(rsp_flags), .rsp_err(rsp_err), .rsp_instr(rsp_instr),
      .op_count(op_count)
   );

   // Behavioural ALU stub: zero = result==0, negative = set-less-than outcome, overflow = signed add/sub.
   logic [31:0] s_rs, s_rt, s_simm, s_zimm, s_r;
   logic        s_lt, s_ov;
   always_comb begin
      s_rs   = alu_instruction[21] ? alu_regB : alu_regA;
      s_rt   = alu_instruction[16] ? alu_regB : alu_regA;
      s_simm = {{16{alu_instruction[15]}}, alu_instruction[15:0]};
      s_zimm = {16'h0, alu_instruction[15:0]};
      s_r    = 32'h0;
      s_lt   = 1'b0;
      s_ov   = 1'b0;
      if (alu_instruction[31:26] == 6'h00) begin
         case (alu_instruction[5:0])
            6'h20: begin s_r = s_rs + s_rt; s_ov = (s_rs[31] == s_rt[31]) && (s_r[31] != s_rs[31]); end
            6'h21: s_r = s_rs + s_rt;
            6'h22: begin s_r = s_rs - s_rt; s_ov = (s_rs[31] != s_rt[31]) && (s_r[31] != s_rs[31]); end
            6'h23: s_r = s_rs - s_rt;
            6'h24: s_r = s_rs & s_rt;
            6'h25: s_r = s_rs | s_rt;
            6'h26: s_r = s_rs ^ s_rt;
            6'h27: s_r = ~(s_rs | s_rt);
            6'h2A: begin s_lt = $signed(s_rs) < $signed(s_rt); s_r = {31'b0, s_lt}; end
            6'h2B: begin s_lt = s_rs < s_rt; s_r = {31'b0, s_lt}; end
            default: s_r = 32'h0;
         endcase
      end else begin
         case (alu_instruction[31:26])
            6'h08: begin s_r = s_rs + s_simm; s_ov = (s_rs[31] == s_simm[31]) && (s_r[31] != s_rs[31]); end
            6'h09: s_r = s_rs + s_simm;
            6'h0A: begin s_lt = $signed(s_rs) < $signed(s_simm); s_r = {31'b0, s_lt}; end
            6'h0B: begin s_lt = s_rs < s_simm; s_r = {31'b0, s_lt}; end
            6'h0C: s_r = s_rs & s_zimm;
            6'h0D: s_r = s_rs | s_zimm;
            6'h0E: s_r = s_rs ^ s_zimm;
            6'h04, 6'h05: s_r = s_rs - s_rt;
            6'h23, 6'h2B: s_r = s_rs + s_simm;
            default: s_r = 32'h0;
         endcase
      end
      alu_result = s_r;
      alu_flags  = {s_ov, s_lt, (s_r == 32'h0)};
   end

   typedef struct packed {
      logic [31:0] res;
      logic [2:0]  fl;
      logic        err;
      logic [31:0] ins;
   } exp_t;

   exp_t          exp_q[$];
   int            checks = 0;
   int            errors = 0;
   logic [31:0]   exp_word = NOP;
   logic [CW-1:0] exp_cnt = '0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, expv);
      end
   endtask

   // Monitor: ALU word legality every cycle, and response pops on each handshake.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!req_ready && !rsp_valid) chk("alu_instr_exec", alu_instruction, exp_word);
         else                          chk("alu_instr_nop", alu_instruction, NOP);
         if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_rsp: got instr %h with no expectation queued", rsp_instr);
            end else begin
               e = exp_q.pop_front();
               chk("rsp_result", rsp_result, e.res);
               chk("rsp_flags", {29'b0, rsp_flags}, {29'b0, e.fl});
               chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
               chk("rsp_instr", rsp_instr, e.ins);
            end
         end
      end
   end

   task automatic issue(input logic [4:0] op, input logic rs, input logic rt,
                        input logic [15:0] imm, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eres, input logic [2:0] efl, input logic eerr,
                        input logic [31:0] eins, input int hold);
      int n;
      exp_word   = eerr ? NOP : eins;
      req_op     = op;
      req_rs_sel = rs;
      req_rt_sel = rt;
      req_imm    = imm;
      req_a      = a;
      req_b      = b;
      req_valid  = 1'b1;
      rsp_ready  = (hold == 0);
      n = 0;
      while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
      @(posedge clk);
      exp_q.push_back('{res: eres, fl: efl, err: eerr, ins: eins});
      #1 req_valid = 1'b0;
      n = 0;
      while (!rsp_valid && n < 40) begin @(posedge clk); #1; n++; end
      chk("latency", n, eerr ? 0 : EXC);
      for (int i = 0; i < hold; i++) begin
         req_valid = 1'b1;
         req_op    = 5'd2;
         chk("hold_result", rsp_result, eres);
         chk("hold_instr", rsp_instr, eins);
         chk("hold_valid", {31'b0, rsp_valid}, 32'd1);
         chk("hold_req_ready", {31'b0, req_ready}, 32'd0);
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      if (!eerr) exp_cnt++;
      chk("op_count", {29'b0, op_count}, {29'b0, exp_cnt});
      chk("rsp_valid_drop", {31'b0, rsp_valid}, 32'd0);
   endtask

   initial begin
      rst_n = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
      req_op = '0; req_rs_sel = 1'b0; req_rt_sel = 1'b0; req_imm = '0; req_a = '0; req_b = '0;
      #1 rst_n = 1'b0;
      #2;
      chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
      chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("rst_rsp_result", rsp_result, 32'h0);
      chk("rst_rsp_instr", rsp_instr, 32'h0);
      chk("rst_flags_err", {28'b0, rsp_flags, rsp_err}, 32'h0);
      chk("rst_op_count", {29'b0, op_count}, 32'h0);
      chk("rst_alu_instr", alu_instruction, NOP);
      chk("rst_regs", alu_regA | alu_regB, 32'h0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      //     op     rs    rt    imm       a             b             result        flags   err   instr         hold
      issue(5'd0,  1'b0, 1'b1, 16'h0000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 3'b100, 1'b0, 32'h00010020, 0);
      issue(5'd1,  1'b0, 1'b0, 16'hFFFF, 32'h00000005, 32'h00000000, 32'h00000004, 3'b000, 1'b0, 32'h2000FFFF, 0);
      issue(5'd13, 1'b0, 1'b1, 16'h0000, 32'h00000003, 32'h00000003, 32'h00000000, 3'b001, 1'b0, 32'h10010000, 0);
      issue(5'd13, 1'b0, 1'b1, 16'h0000, 32'h00000003, 32'h00000004, 32'hFFFFFFFF, 3'b000, 1'b0, 32'h10010000, 0);
      issue(5'd17, 1'b0, 1'b0, 16'hFFFF, 32'h12345678, 32'h00000000, 32'h00000001, 3'b010, 1'b0, 32'h2C00FFFF, 0);
      issue(5'd20, 1'b0, 1'b1, 16'h0010, 32'h00000100, 32'h00000000, 32'h00000110, 3'b000, 1'b0, 32'hAC010010, 0);
      issue(5'd25, 1'b0, 1'b1, 16'h1234, 32'h00000001, 32'h00000002, 32'h00000000, 3'b000, 1'b1, 32'h00000000, 0);
      issue(5'd4,  1'b1, 1'b0, 16'h0000, 32'h00000005, 32'h00000003, 32'hFFFFFFFE, 3'b000, 1'b0, 32'h00200022, 0);
      issue(5'd11, 1'b0, 1'b1, 16'h0000, 32'hF0F0F0F0, 32'hFFFFFFFF, 32'h0F0F0F0F, 3'b000, 1'b0, 32'h00010026, 0);
      issue(5'd8,  1'b0, 1'b0, 16'h0000, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 3'b001, 1'b0, 32'h00000027, 0);
      issue(5'd15, 1'b0, 1'b1, 16'h0000, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 3'b010, 1'b0, 32'h0001002A, 0);
      issue(5'd10, 1'b1, 1'b0, 16'h00F0, 32'h00000000, 32'h0000000F, 32'h000000FF, 3'b000, 1'b0, 32'h342000F0, 0);
      issue(5'd7,  1'b0, 1'b1, 16'hFF00, 32'h00001234, 32'h00000000, 32'h00001200, 3'b000, 1'b0, 32'h3001FF00, 0);
      issue(5'd2,  1'b0, 1'b1, 16'h0000, 32'h00000001, 32'h00000002, 32'h00000003, 3'b000, 1'b0, 32'h00010021, 5);

      // Reset in the middle of EXEC drops the operation.
      exp_word = 32'h00010021;
      req_op = 5'd2; req_rs_sel = 1'b0; req_rt_sel = 1'b1; req_a = 32'h10; req_b = 32'h20;
      req_valid = 1'b1; rsp_ready = 1'b1;
      @(posedge clk);
      exp_q.push_back('{res: 32'h30, fl: 3'b000, err: 1'b0, ins: 32'h00010021});
      #1 req_valid = 1'b0;
      @(posedge clk); #1;
      chk("mid_exec_instr", alu_instruction, 32'h00010021);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_exec_alu_instr", alu_instruction, NOP);
      chk("rst_exec_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("rst_exec_op_count", {29'b0, op_count}, 32'd0);
      chk("rst_exec_req_ready", {31'b0, req_ready}, 32'd1);
      exp_q.delete();
      exp_cnt  = '0;
      exp_word = NOP;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      issue(5'd19, 1'b0, 1'b0, 16'h0004, 32'h00001000, 32'h00000000, 32'h00001004, 3'b000, 1'b0, 32'h8C000004, 0);

      repeat (3) @(posedge clk);
      #1;
      chk("queue_drained", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
